// File: rtl/vga_pkg.sv
// Shared 640x480 VGA timing constants, box-renderer palette and axis state type.
package vga_pkg;

   localparam int unsigned HPIXELS = 800;
   localparam int unsigned VLINES  = 521;
   localparam int unsigned HBP     = 144;
   localparam int unsigned HFP     = 784;
   localparam int unsigned VBP     = 31;
   localparam int unsigned VFP     = 511;
   localparam int unsigned HACTIVE = HFP - HBP;
   localparam int unsigned VACTIVE = VFP - VBP;

   typedef logic [8:0] rgb_t;

   // Entry 0 sits in the low word so cidx indexes it directly.
   localparam logic [7:0][8:0] PALETTE = {
      9'b100_100_100,
      9'b111_111_111,
      9'b000_111_111,
      9'b111_000_111,
      9'b111_111_000,
      9'b000_000_111,
      9'b000_111_000,
      9'b111_000_000
   };

   localparam logic [3:0] STEP_MIN = 4'd1;
   localparam logic [3:0] STEP_MAX = 4'd8;

   typedef enum logic {
      FWD,
      REV
   } dir_t;

endpackage

// File: rtl/box_renderer_axis.sv
// One bouncing axis: position moves by step each update and reflects off 0 and LIMIT-BOX.
module box_axis
   import vga_pkg::*;
#(
   parameter int unsigned LIMIT = HACTIVE,
   parameter int unsigned BOX   = 32
) (
   input  logic       dclk,
   input  logic       rst_n,
   input  logic       upd,
   input  logic [3:0] step,
   output logic [9:0] pos,
   output logic       hit
);

   localparam logic [10:0] LIM  = 11'(LIMIT);
   localparam logic [10:0] SIDE = 11'(BOX);
   localparam logic [10:0] TOP  = 11'(LIMIT - BOX);

   dir_t        state;
   logic [10:0] p;
   logic [10:0] stp;

   assign stp = {7'd0, step};

   // 11-bit arithmetic keeps pos+BOX+step and pos-step free of wrap-around.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FWD;
         p     <= '0;
         hit   <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (upd) begin
            case (state)
               FWD: begin
                  if (p + SIDE + stp > LIM) begin
                     p     <= TOP;
                     state <= REV;
                     hit   <= 1'b1;
                  end else begin
                     p <= p + stp;
                  end
               end
               REV: begin
                  if (p < stp) begin
                     p     <= '0;
                     state <= FWD;
                     hit   <= 1'b1;
                  end else begin
                     p <= p - stp;
                  end
               end
               default: begin
                  p     <= '0;
                  state <= FWD;
               end
            endcase
         end
      end
   end

   assign pos = p[9:0];

endmodule

// File: rtl/box_renderer.sv
// Pixel source for the 640x480 timing generator: a solid box bouncing over a flat background.
module box_renderer #(
   parameter int unsigned HPIXELS = vga_pkg::HPIXELS,
   parameter int unsigned VLINES  = vga_pkg::VLINES,
   parameter int unsigned HBP     = vga_pkg::HBP,
   parameter int unsigned HFP     = vga_pkg::HFP,
   parameter int unsigned VBP     = vga_pkg::VBP,
   parameter int unsigned VFP     = vga_pkg::VFP,
   parameter int unsigned BOX     = 32,
   parameter logic [8:0]  BG      = 9'b000_000_001
) (
   input  logic       dclk,
   input  logic       rst_n,
   input  logic [9:0] hc,
   input  logic [9:0] vc,
   input  logic       pause,
   input  logic       speed_up,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [2:0] blue,
   output logic       bounce
);

   import vga_pkg::*;

   logic [9:0] bx;
   logic [9:0] by;
   logic       hit_x;
   logic       hit_y;
   logic [3:0] step;
   logic [2:0] cidx;
   logic       upd;
   logic       active;
   logic       in_box;
   logic [9:0] x;
   logic [9:0] y;
   rgb_t       pixel;
   rgb_t       rgb;

   assign upd = (hc == '0) && (vc == 10'(VFP)) && !pause;

   assign active = ({1'b0, hc} < 11'(HPIXELS)) && ({1'b0, vc} < 11'(VLINES)) &&
                   (hc >= 10'(HBP)) && (hc < 10'(HFP)) &&
                   (vc >= 10'(VBP)) && (vc < 10'(VFP));

   assign x = hc - 10'(HBP);
   assign y = vc - 10'(VBP);

   assign in_box = (x >= bx) && ({1'b0, x} < {1'b0, bx} + 11'(BOX)) &&
                   (y >= by) && ({1'b0, y} < {1'b0, by} + 11'(BOX));

   always_comb begin
      pixel = '0;
      if (active) begin
         pixel = in_box ? PALETTE[cidx] : BG;
      end
   end

   box_axis #(
      .LIMIT (HFP - HBP),
      .BOX   (BOX)
   ) u_axis_x (
      .dclk  (dclk),
      .rst_n (rst_n),
      .upd   (upd),
      .step  (step),
      .pos   (bx),
      .hit   (hit_x)
   );

   box_axis #(
      .LIMIT (VFP - VBP),
      .BOX   (BOX)
   ) u_axis_y (
      .dclk  (dclk),
      .rst_n (rst_n),
      .upd   (upd),
      .step  (step),
      .pos   (by),
      .hit   (hit_y)
   );

   // Hits are registered in the axes, so cidx advances on the cycle after upd, still in blanking.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         step <= STEP_MIN;
         cidx <= '0;
         rgb  <= '0;
      end else begin
         if (speed_up && (step < STEP_MAX)) begin
            step <= step + 4'd1;
         end
         if (hit_x || hit_y) begin
            cidx <= cidx + 3'd1;
         end
         rgb <= pixel;
      end
   end

   assign {red, green, blue} = rgb;
   assign bounce = hit_x | hit_y;

endmodule
